// File: rtl/lcd_write_sequencer.sv
// Physical-layer write engine for a 4-bit character LCD: drives DB[7:4], RS and E
// with setup/pulse/hold timing and inter-nibble/inter-byte gaps, then pulses done.
module lcd_write_sequencer #(
  parameter int SETUP_CYCLES      = 2,
  parameter int PULSE_CYCLES      = 12,
  parameter int HOLD_CYCLES       = 1,
  parameter int NIBBLE_GAP_CYCLES = 50,
  parameter int BYTE_GAP_CYCLES   = 2000,
  parameter int CNT_W             = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iWrite,
  input  logic [7:0] iData,
  input  logic       iRegisterSelect,
  input  logic       iNibbleOnly,
  output logic       oBusy,
  output logic       oWriteDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic [3:0] oLCD_Data
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] NGAP_LAST  = CNT_W'(NIBBLE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BGAP_LAST  = CNT_W'(BYTE_GAP_CYCLES - 1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       low_r, low_s;
  logic             nib_only_r, nib_only_s;
  logic             nib_idx_r, nib_idx_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             e_r, e_s;
  logic             rs_r, rs_s;
  logic [3:0]       data_r, data_s;

  // State, counter, latched request and all registered outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      low_r      <= 4'h0;
      nib_only_r <= 1'b0;
      nib_idx_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      e_r        <= 1'b0;
      rs_r       <= 1'b0;
      data_r     <= 4'h0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      low_r      <= low_s;
      nib_only_r <= nib_only_s;
      nib_idx_r  <= nib_idx_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      e_r        <= e_s;
      rs_r       <= rs_s;
      data_r     <= data_s;
    end
  end

  // Next-state, next-output and counter logic
  always_comb begin
    state_s    = state_r;
    low_s      = low_r;
    nib_only_s = nib_only_r;
    nib_idx_s  = nib_idx_r;
    rs_s       = rs_r;
    data_s     = data_r;
    case (state_r)
      ST_IDLE: begin
        if (iWrite) begin
          state_s    = ST_SETUP;
          low_s      = iData[3:0];
          rs_s       = iRegisterSelect;
          nib_only_s = iNibbleOnly;
          nib_idx_s  = 1'b0;
          data_s     = iNibbleOnly ? iData[3:0] : iData[7:4];
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == SETUP_LAST) state_s = ST_PULSE;
        else                     state_s = ST_SETUP;
      end
      ST_PULSE: begin
        if (cnt_r == PULSE_LAST) state_s = ST_HOLD;
        else                     state_s = ST_PULSE;
      end
      ST_HOLD: begin
        if (cnt_r == HOLD_LAST) state_s = ST_GAP;
        else                    state_s = ST_HOLD;
      end
      ST_GAP: begin
        // Only the high nibble of a full byte is followed by the short gap
        if (!nib_only_r && !nib_idx_r) begin
          if (cnt_r == NGAP_LAST) begin
            state_s   = ST_SETUP;
            nib_idx_s = 1'b1;
            data_s    = low_r;
          end else begin
            state_s = ST_GAP;
          end
        end else begin
          if (cnt_r == BGAP_LAST) state_s = ST_DONE;
          else                    state_s = ST_GAP;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if ((state_s != state_r) || (state_r == ST_IDLE)) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end

    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_DONE);
    e_s    = (state_s == ST_PULSE);
  end

  assign oBusy               = busy_r;
  assign oWriteDone          = done_r;
  assign oLCD_Enabled        = e_r;
  assign oLCD_RegisterSelect = rs_r;
  assign oLCD_Data           = data_r;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Self-checking bench for lcd_write_sequencer: directed scenarios plus random traffic,
// compared every cycle against a timeline model derived from the accept time.
module tb_lcd_write_sequencer;

  localparam int S        = 2;
  localparam int P        = 12;
  localparam int H        = 1;
  localparam int N        = 50;
  localparam int B        = 2000;
  localparam int T_NIB    = S + P + H + N;
  localparam int LAT_BYTE = 2 * (S + P + H) + N + B;
  localparam int LAT_NIB  = S + P + H + B;

  logic       Clock;
  logic       Reset;
  logic       iWrite;
  logic [7:0] iData;
  logic       iRegisterSelect;
  logic       iNibbleOnly;
  logic       oBusy;
  logic       oWriteDone;
  logic       oLCD_Enabled;
  logic       oLCD_RegisterSelect;
  logic [3:0] oLCD_Data;

  lcd_write_sequencer dut (
    .Clock               (Clock),
    .Reset               (Reset),
    .iWrite              (iWrite),
    .iData               (iData),
    .iRegisterSelect     (iRegisterSelect),
    .iNibbleOnly         (iNibbleOnly),
    .oBusy               (oBusy),
    .oWriteDone          (oWriteDone),
    .oLCD_Enabled        (oLCD_Enabled),
    .oLCD_RegisterSelect (oLCD_RegisterSelect),
    .oLCD_Data           (oLCD_Data)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int cyc = 0;

  // Reference model: the last accepted transaction and its accept cycle
  bit         have_txn = 1'b0;
  int         acc_cyc = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_rs = 1'b0;
  logic       m_nib = 1'b0;
  int         accepts = 0;

  logic       prev_e = 1'b0;
  logic [3:0] rise_q[$];
  int         rise_cyc_q[$];
  int         done_cnt = 0;
  int         last_done_cyc = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int lat();
    return m_nib ? LAT_NIB : LAT_BYTE;
  endfunction

  function automatic bit model_idle();
    return !have_txn || ((cyc - acc_cyc) > lat());
  endfunction

  // Expected {busy, done, E, RS, data} in cycle t
  function automatic logic [7:0] model_out(input int t);
    int         off;
    logic       busy;
    logic       done;
    logic       e;
    logic [3:0] d;
    if (!have_txn) return 8'h00;
    off  = t - acc_cyc;
    busy = (off <= lat());
    done = (off == lat());
    e    = ((off >= S) && (off < S + P)) ||
           (!m_nib && (off >= T_NIB + S) && (off < T_NIB + S + P));
    d    = (m_nib || (off >= T_NIB)) ? m_data[3:0] : m_data[7:4];
    return {1'b0, busy, done, e, m_rs, d};
  endfunction

  task automatic step();
    bit         acc;
    logic [7:0] cap_d;
    logic       cap_rs;
    logic       cap_nib;
    acc     = (Reset === 1'b1) && (iWrite === 1'b1) && model_idle();
    cap_d   = iData;
    cap_rs  = iRegisterSelect;
    cap_nib = iNibbleOnly;
    @(posedge Clock);
    cyc++;
    if (acc) begin
      have_txn = 1'b1;
      acc_cyc  = cyc;
      m_data   = cap_d;
      m_rs     = cap_rs;
      m_nib    = cap_nib;
      accepts++;
    end
    @(negedge Clock);
    check_eq("outputs", {24'h0, 1'b0, oBusy, oWriteDone, oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data},
             {24'h0, model_out(cyc)});
    if (oLCD_Enabled && !prev_e) begin
      rise_q.push_back(oLCD_Data);
      rise_cyc_q.push_back(cyc);
    end
    prev_e = oLCD_Enabled;
    if (oWriteDone) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  endtask

  task automatic run_to_idle();
    for (int k = 0; (k < LAT_BYTE + 10) && !model_idle(); k++) step();
    step();
    check_eq("idle_busy", {31'h0, oBusy}, 32'h0);
  endtask

  // Accept one request, then run it to completion and check its latency
  task automatic send(input logic [7:0] d, input logic rs, input logic nib);
    iData = d; iRegisterSelect = rs; iNibbleOnly = nib; iWrite = 1'b1;
    last_done_cyc = -1;
    rise_q.delete(); rise_cyc_q.delete();
    step();
    iWrite = 1'b0;
    check_eq("accepted", {31'h0, oBusy}, 32'h1);
    run_to_idle();
    check_eq("latency", 32'(last_done_cyc - acc_cyc), 32'(nib ? LAT_NIB : LAT_BYTE));
  endtask

  initial begin
    int         base_done;
    logic [3:0] exp4[4];
    Reset = 1'b0; iWrite = 1'b0; iData = 8'h00; iRegisterSelect = 1'b0; iNibbleOnly = 1'b0;

    // Reset hold and release with no requests
    for (int i = 0; i < 5; i++) step();
    Reset = 1'b1;
    rise_q.delete();
    for (int i = 0; i < 40; i++) step();
    check_eq("idle_no_pulse", 32'(rise_q.size()), 32'd0);

    // Full byte 0x28, command
    send(8'h28, 1'b0, 1'b0);
    check_eq("t28_rises", 32'(rise_q.size()), 32'd2);
    if (rise_q.size() == 2) begin
      check_eq("t28_hi", {28'h0, rise_q[0]}, 32'h2);
      check_eq("t28_lo", {28'h0, rise_q[1]}, 32'h8);
      check_eq("t28_spacing", 32'(rise_cyc_q[1] - rise_cyc_q[0]), 32'd65);
    end

    // Nibble-only init write 0x3
    send(8'h03, 1'b0, 1'b1);
    check_eq("t03_rises", 32'(rise_q.size()), 32'd1);
    if (rise_q.size() == 1) check_eq("t03_data", {28'h0, rise_q[0]}, 32'h3);

    // iWrite held across two requests; data swapped after the first done
    rise_q.delete();
    base_done = done_cnt;
    accepts = 0;
    iData = 8'h06; iRegisterSelect = 1'b0; iNibbleOnly = 1'b0; iWrite = 1'b1;
    for (int k = 0; k < 2 * LAT_BYTE + 20; k++) begin
      step();
      if (oWriteDone && accepts == 1) iData = 8'h0F;
      if (accepts == 2 && cyc == acc_cyc) iWrite = 1'b0;
      if (accepts == 2 && model_idle()) break;
    end
    iWrite = 1'b0;
    step();
    check_eq("hold_done_pulses", 32'(done_cnt - base_done), 32'd2);
    check_eq("hold_rises", 32'(rise_q.size()), 32'd4);
    exp4[0] = 4'h0; exp4[1] = 4'h6; exp4[2] = 4'h0; exp4[3] = 4'hF;
    for (int i = 0; i < 4 && i < rise_q.size(); i++) check_eq("hold_seq", {28'h0, rise_q[i]}, {28'h0, exp4[i]});

    // Input garbage and iWrite drop mid-transaction must not disturb 0x41/RS=1
    rise_q.delete();
    base_done = done_cnt;
    iData = 8'h41; iRegisterSelect = 1'b1; iNibbleOnly = 1'b0; iWrite = 1'b1;
    step();
    for (int k = 0; k < 5; k++) step();
    iData = 8'hFF; iWrite = 1'b0; iRegisterSelect = 1'b0; iNibbleOnly = 1'b1;
    run_to_idle();
    check_eq("t41_done", 32'(done_cnt - base_done), 32'd1);
    check_eq("t41_rises", 32'(rise_q.size()), 32'd2);
    if (rise_q.size() == 2) begin
      check_eq("t41_hi", {28'h0, rise_q[0]}, 32'h4);
      check_eq("t41_lo", {28'h0, rise_q[1]}, 32'h1);
    end

    // Asynchronous reset while E is high
    base_done = done_cnt;
    iData = 8'h55; iRegisterSelect = 1'b1; iNibbleOnly = 1'b0; iWrite = 1'b1;
    step();
    iWrite = 1'b0;
    for (int k = 0; k < 8; k++) step();
    check_eq("pre_reset_e", {31'h0, oLCD_Enabled}, 32'h1);
    #2 Reset = 1'b0;
    #1;
    check_eq("async_e_drop", {31'h0, oLCD_Enabled}, 32'h0);
    check_eq("async_all_zero",
             {24'h0, 1'b0, oBusy, oWriteDone, oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data}, 32'h0);
    have_txn = 1'b0;
    prev_e = 1'b0;
    for (int k = 0; k < 3; k++) step();
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check_eq("reset_no_done", 32'(done_cnt - base_done), 32'd0);
    send(8'h01, 1'b0, 1'b0);

    // Random traffic: sparse requests, inputs churning every cycle
    for (int k = 0; k < 12000; k++) begin
      iWrite          = ($urandom_range(0, 15) == 0);
      iData           = 8'($urandom);
      iRegisterSelect = 1'($urandom);
      iNibbleOnly     = 1'($urandom);
      step();
    end
    iWrite = 1'b0;
    run_to_idle();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
